// File: rtl/fios_res_collector.sv
// fios_res_collector
//
// Downstream collector for the FIOS PE chain. Gathers the serial result words
// leaving the last PE, least-significant word first, into one WORD_COUNT-word
// Montgomery product. The product is then offered on a valid/ready handshake.
//
// Build option: define FIOS_RES_FINAL_SUB_EN to also compute result - p word
// by word as the words arrive. The held output is then the reduced value
// whenever result >= p. With the macro undefined, p_word_i is ignored.
//
// Ports
//   clock_i       rising-edge clock
//   reset_n_i     synchronous active-low reset
//   start_i       begin a new collection (clears word counter and overrun_o)
//   word_valid_i  word_i carries a result word this cycle
//   word_i        result word, least-significant first
//   p_word_i      modulus word aligned with word_i (final-subtract build only)
//   res_o         assembled result, word k at [k*WORD_WIDTH +: WORD_WIDTH]
//   res_valid_o   res_o valid and stable (HOLD)
//   res_ready_i   consumer accepts res_o
//   busy_o        collecting words
//   overrun_o     sticky: a word arrived while not collecting
module fios_res_collector #(
  parameter int unsigned WORD_WIDTH = 17,
  parameter int unsigned WORD_COUNT = 16
) (
  input  logic                             clock_i,
  input  logic                             reset_n_i,
  input  logic                             start_i,
  input  logic                             word_valid_i,
  input  logic [WORD_WIDTH-1:0]            word_i,
  input  logic [WORD_WIDTH-1:0]            p_word_i,
  output logic [WORD_COUNT*WORD_WIDTH-1:0] res_o,
  output logic                             res_valid_o,
  input  logic                             res_ready_i,
  output logic                             busy_o,
  output logic                             overrun_o
);

  localparam int unsigned CntW = $clog2(WORD_COUNT);

  typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  overrun_q, overrun_d;
  logic [WORD_WIDTH-1:0] raw_q [WORD_COUNT];
  logic [WORD_WIDTH-1:0] raw_d [WORD_COUNT];
  logic [WORD_WIDTH-1:0] out_w [WORD_COUNT];
  logic                  accept;  // word_i is stored this cycle
  logic                  clear;   // a start takes effect this cycle

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    accept    = 1'b0;
    clear     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StCollect;
          clear   = 1'b1;
        end else if (word_valid_i) begin
          overrun_d = 1'b1;
        end
      end
      StCollect: begin
        // start wins over a coincident word: the partial result is discarded
        if (start_i) begin
          clear = 1'b1;
        end else if (word_valid_i) begin
          accept = 1'b1;
          if (cnt_q == CntW'(WORD_COUNT - 1)) begin
            state_d = StHold;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StHold: begin
        // start without a handshake is ignored so a held result is never lost
        if (res_ready_i && start_i) begin
          state_d = StCollect;
          clear   = 1'b1;
        end else begin
          if (res_ready_i) begin
            state_d = StIdle;
          end
          if (word_valid_i) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (clear) begin
      cnt_d     = '0;
      overrun_d = 1'b0;
    end
  end

  always_comb begin
    raw_d = raw_q;
    if (accept) begin
      raw_d[cnt_q] = word_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < int'(WORD_COUNT); k++) begin
        raw_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      raw_q     <= raw_d;
    end
  end

`ifdef FIOS_RES_FINAL_SUB_EN
  logic [WORD_WIDTH-1:0] diff_q [WORD_COUNT];
  logic [WORD_WIDTH-1:0] diff_d [WORD_COUNT];
  logic                  borrow_q, borrow_d;
  logic [WORD_WIDTH:0]   diff;

  // Word-serial subtraction: the top bit of the (W+1)-bit difference is the
  // borrow into the next word. A borrow out of the last word means result < p.
  always_comb begin
    diff     = {1'b0, word_i} - {1'b0, p_word_i} - {{WORD_WIDTH{1'b0}}, borrow_q};
    diff_d   = diff_q;
    borrow_d = borrow_q;
    if (clear) begin
      borrow_d = 1'b0;
    end else if (accept) begin
      diff_d[cnt_q] = diff[WORD_WIDTH-1:0];
      borrow_d      = diff[WORD_WIDTH];
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      borrow_q <= 1'b0;
      for (int k = 0; k < int'(WORD_COUNT); k++) begin
        diff_q[k] <= '0;
      end
    end else begin
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
    end
  end

  always_comb begin
    for (int k = 0; k < int'(WORD_COUNT); k++) begin
      out_w[k] = borrow_q ? raw_q[k] : diff_q[k];
    end
  end
`else
  logic unused_p_word;
  assign unused_p_word = ^p_word_i;

  always_comb begin
    out_w = raw_q;
  end
`endif

  for (genvar k = 0; k < int'(WORD_COUNT); k++) begin : g_res
    assign res_o[k*WORD_WIDTH +: WORD_WIDTH] = out_w[k];
  end

  assign res_valid_o = (state_q == StHold);
  assign busy_o      = (state_q == StCollect);
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_fios_res_collector.sv
module tb_fios_res_collector;

  localparam int unsigned W  = 17;
  localparam int unsigned N  = 4;
  localparam int unsigned RW = W * N;

  logic          clock_i = 1'b0;
  logic          reset_n_i;
  logic          start_i;
  logic          word_valid_i;
  logic [W-1:0]  word_i;
  logic [W-1:0]  p_word_i;
  logic [RW-1:0] res_o;
  logic          res_valid_o;
  logic          res_ready_i;
  logic          busy_o;
  logic          overrun_o;

  fios_res_collector #(
    .WORD_WIDTH(W),
    .WORD_COUNT(N)
  ) dut (
    .clock_i      (clock_i),
    .reset_n_i    (reset_n_i),
    .start_i      (start_i),
    .word_valid_i (word_valid_i),
    .word_i       (word_i),
    .p_word_i     (p_word_i),
    .res_o        (res_o),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [RW-1:0] r;
    logic [RW-1:0] p;
    int            gap;
    int            bp;
    logic [RW-1:0] exp;
  } vec_t;

  vec_t          tbl[5];
  logic [RW-1:0] exp_q[$];
  int            passed = 0;
  int            total  = 0;

  // Whole-number reference: one conditional subtraction of p.
  function automatic logic [RW-1:0] model(input logic [RW-1:0] r, input logic [RW-1:0] p);
`ifdef FIOS_RES_FINAL_SUB_EN
    return (r >= p) ? r - p : r;
`else
    return r;
`endif
  endfunction

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic start_pulse();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Feed N words with 'gap' idle cycles between them; expectation is queued.
  task automatic send(input logic [RW-1:0] r, input logic [RW-1:0] p, input int gap,
                      input logic [RW-1:0] exp);
    for (int i = 0; i < int'(N); i++) begin
      word_valid_i = 1'b1;
      word_i       = r[i*W +: W];
      p_word_i     = p[i*W +: W];
      if (i == int'(N) - 1) begin
        chk("valid_before_last", {67'd0, res_valid_o}, 68'd0);
        chk("busy_before_last", {67'd0, busy_o}, 68'd1);
      end
      tick();
      word_valid_i = 1'b0;
      word_i       = '0;
      p_word_i     = '0;
      if (i < int'(N) - 1) repeat (gap) tick();
    end
    exp_q.push_back(exp);
    chk("valid_latency", {67'd0, res_valid_o}, 68'd1);
    chk("busy_falls", {67'd0, busy_o}, 68'd0);
  endtask

  // Hold off for 'bp' cycles, then accept; compares against the queue head.
  task automatic drain(input int bp);
    logic [RW-1:0] e;
    int n = 0;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 68'd1, 68'd0);
      return;
    end
    e = exp_q.pop_front();
    while (!res_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("valid_wait", {67'd0, res_valid_o}, 68'd1);
    for (int i = 0; i < bp; i++) begin
      chk("hold_stable", res_o, e);
      chk("hold_valid", {67'd0, res_valid_o}, 68'd1);
      tick();
    end
    res_ready_i = 1'b1;
    chk("res_at_handshake", res_o, e);
    tick();
    res_ready_i = 1'b0;
    chk("valid_falls", {67'd0, res_valid_o}, 68'd0);
  endtask

  initial begin
    logic [RW-1:0] e;
    reset_n_i    = 1'b0;
    start_i      = 1'b0;
    word_valid_i = 1'b0;
    word_i       = '0;
    p_word_i     = '0;
    res_ready_i  = 1'b0;

    tbl[0] = '{r: {17'h1FFFF, 17'h00003, 17'h00002, 17'h00001}, p: '0, gap: 0, bp: 0, exp: '0};
    tbl[1] = '{r: {17'h0BEEF, 17'h12345, 17'h1A5A5, 17'h00F0F}, p: {17'h0BEEF, 17'h00001, 17'h0, 17'h0},
               gap: 3, bp: 5, exp: '0};
    tbl[2] = '{r: {17'h0, 17'h0, 17'h0, 17'h00010}, p: {17'h0, 17'h0, 17'h0, 17'h00007},
               gap: 0, bp: 1, exp: '0};
    tbl[3] = '{r: {17'h0, 17'h0, 17'h0, 17'h00005}, p: {17'h0, 17'h0, 17'h0, 17'h00007},
               gap: 1, bp: 2, exp: '0};
    tbl[4] = '{r: {17'h00001, 17'h0, 17'h0, 17'h0}, p: {17'h0, 17'h1FFFF, 17'h0, 17'h00005},
               gap: 0, bp: 0, exp: '0};
    for (int i = 0; i < 5; i++) tbl[i].exp = model(tbl[i].r, tbl[i].p);

    tick();
    tick();
    chk("rst_res", res_o, '0);
    chk("rst_valid", {67'd0, res_valid_o}, 68'd0);
    chk("rst_busy", {67'd0, busy_o}, 68'd0);
    chk("rst_overrun", {67'd0, overrun_o}, 68'd0);
    reset_n_i = 1'b1;
    tick();

    // Table-driven collections
    for (int i = 0; i < 5; i++) begin
      start_pulse();
      chk("busy_after_start", {67'd0, busy_o}, 68'd1);
      send(tbl[i].r, tbl[i].p, tbl[i].gap, tbl[i].exp);
      drain(tbl[i].bp);
    end

    // Overrun in IDLE is sticky and cleared by start
    word_valid_i = 1'b1;
    word_i       = 17'h1DEAD;
    tick();
    word_valid_i = 1'b0;
    chk("overrun_idle", {67'd0, overrun_o}, 68'd1);
    repeat (3) tick();
    chk("overrun_sticky", {67'd0, overrun_o}, 68'd1);
    start_pulse();
    chk("overrun_cleared", {67'd0, overrun_o}, 68'd0);

    // Restart after 2 words: only the new words survive
    send_partial(2);
    start_pulse();
    send(tbl[1].r, tbl[1].p, 0, tbl[1].exp);
    // Word in HOLD: flags overrun, result untouched
    word_valid_i = 1'b1;
    word_i       = 17'h15555;
    tick();
    word_valid_i = 1'b0;
    chk("overrun_hold", {67'd0, overrun_o}, 68'd1);
    chk("hold_after_stray", res_o, tbl[1].exp);
    // Handshake together with start goes straight back to COLLECT
    e = exp_q.pop_front();
    res_ready_i = 1'b1;
    start_i     = 1'b1;
    chk("res_before_restart", res_o, e);
    tick();
    res_ready_i = 1'b0;
    start_i     = 1'b0;
    chk("hold_exit_valid", {67'd0, res_valid_o}, 68'd0);
    chk("hold_exit_busy", {67'd0, busy_o}, 68'd1);
    chk("hold_exit_overrun", {67'd0, overrun_o}, 68'd0);
    send(tbl[0].r, tbl[0].p, 0, tbl[0].exp);
    drain(0);

    // start together with a word in IDLE: word dropped, no overrun
    start_i      = 1'b1;
    word_valid_i = 1'b1;
    word_i       = 17'h1ABCD;
    tick();
    start_i      = 1'b0;
    word_valid_i = 1'b0;
    chk("start_word_overrun", {67'd0, overrun_o}, 68'd0);
    send(tbl[2].r, tbl[2].p, 0, tbl[2].exp);
    drain(0);

    // Reset during COLLECT clears everything and lands in IDLE
    start_pulse();
    send_partial(2);
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    chk("midrst_res", res_o, '0);
    chk("midrst_valid", {67'd0, res_valid_o}, 68'd0);
    chk("midrst_busy", {67'd0, busy_o}, 68'd0);
    chk("midrst_overrun", {67'd0, overrun_o}, 68'd0);
    word_valid_i = 1'b1;
    word_i       = 17'h00123;
    tick();
    word_valid_i = 1'b0;
    chk("midrst_idle", {67'd0, overrun_o}, 68'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) begin
      word_valid_i = 1'b1;
      word_i       = 17'h1F000 | W'(i);
      p_word_i     = 17'h00F00;
      tick();
    end
    word_valid_i = 1'b0;
    word_i       = '0;
    p_word_i     = '0;
  endtask

endmodule
